// File: rtl/block_rate_meter.sv
// block_rate_meter: measures cycles between answ rising edges and publishes period and min/max statistics.
module block_rate_meter #(
    parameter int CNT_W = 32,
    parameter int NUM_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             answ,
    input  logic             res_ready,
    output logic             res_valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] min_period,
    output logic [CNT_W-1:0] max_period,
    output logic [NUM_W-1:0] intervals,
    output logic             overrun,
    output logic             saturated
);
    typedef enum logic {IDLE, MEASURE} state_t;
    localparam logic [CNT_W-1:0] cnt_max = '1;
    localparam logic [NUM_W-1:0] num_max = '1;
    state_t state, state_nx;
    logic answ_d, rise, arm, load;
    logic [CNT_W-1:0] cnt;
    assign rise = answ & ~answ_d;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end
    always_comb state_nx = !enable ? IDLE : (state == IDLE && rise) ? MEASURE : state;
    always_comb begin
        arm  = enable && state == IDLE && rise;
        load = enable && state == MEASURE && rise;
    end
    // answ_d keeps tracking while disabled so a level already high at enable does not count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            answ_d     <= 1'b0;
            cnt        <= '0;
            res_valid  <= 1'b0;
            period     <= '0;
            min_period <= cnt_max;
            max_period <= '0;
            intervals  <= '0;
            overrun    <= 1'b0;
            saturated  <= 1'b0;
        end else begin
            answ_d <= answ;
            if (!enable) begin
                cnt        <= '0;
                res_valid  <= 1'b0;
                period     <= '0;
                min_period <= cnt_max;
                max_period <= '0;
                intervals  <= '0;
                overrun    <= 1'b0;
                saturated  <= 1'b0;
            end else begin
                if (arm || load)                          cnt <= CNT_W'(1);
                else if (state == MEASURE && cnt != cnt_max) cnt <= cnt + CNT_W'(1);
                if (load) begin
                    period     <= cnt;
                    saturated  <= cnt == cnt_max;
                    min_period <= (cnt < min_period) ? cnt : min_period;
                    max_period <= (cnt > max_period) ? cnt : max_period;
                    intervals  <= (intervals == num_max) ? intervals : intervals + NUM_W'(1);
                    overrun    <= overrun | (res_valid & ~res_ready);
                    res_valid  <= 1'b1;
                end else if (res_ready) begin
                    res_valid  <= 1'b0;
                end
            end
        end
    end
endmodule
